// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle layout and occupancy encoding for the
// stage-boundary skid registers of the SIMD AES pipeline.
package pipe_pkg;

  localparam int N_DEF = 32;
  localparam int V_DEF = 256;
  localparam int R_DEF = 5;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic reg_write_v;
    logic mem_to_reg;
  } pipe_ctrl_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_slot.sv
// One buffered pipeline entry: valid, control bundle, packed lane data and
// write address. Flush kills valid and control but leaves the payload.
module pipe_slot #(
  parameter int DW = 64,
  parameter int C  = 4,
  parameter int R  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          clear,
  input  logic [C-1:0]  d_ctrl,
  input  logic [DW-1:0] d_data,
  input  logic [R-1:0]  d_wa,
  output logic          valid,
  output logic [C-1:0]  ctrl,
  output logic [DW-1:0] data,
  output logic [R-1:0]  wa
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
      wa    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
      wa    <= d_wa;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_skid_register.sv
// Valid/ready stage-boundary register with a 2-entry skid buffer, flush to
// bubble, bubble control gating and a saturating stall-cycle counter.
module pipeline_skid_register
  import pipe_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int V  = V_DEF,
  parameter int NS = 2,
  parameter int NV = 2,
  parameter int C  = $bits(pipe_ctrl_t),
  parameter int R  = R_DEF,
  parameter int SC = 16,
  localparam int VW = (NV > 0) ? NV * V : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [C-1:0]    in_ctrl,
  input  logic [NS*N-1:0] in_scalar,
  input  logic [VW-1:0]   in_vector,
  input  logic [R-1:0]    in_wa,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [C-1:0]    out_ctrl,
  output logic [NS*N-1:0] out_scalar,
  output logic [VW-1:0]   out_vector,
  output logic [R-1:0]    out_wa,
  output logic [1:0]      occupancy,
  output logic [SC-1:0]   stall_cycles
);

  localparam int DW = NS * N + NV * V;

  if (NS < 1) begin : g_bad_ns
    $error("pipeline_skid_register: NS must be >= 1");
  end
  if (NV < 0) begin : g_bad_nv
    $error("pipeline_skid_register: NV must be >= 0");
  end
  if (C < 1) begin : g_bad_c
    $error("pipeline_skid_register: C must be >= 1");
  end

  function automatic logic [SC-1:0] sat_inc(input logic [SC-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DW-1:0] in_data;
  logic          head_vld, skid_vld;
  logic [C-1:0]  head_ctrl, skid_ctrl, head_ctrl_d;
  logic [DW-1:0] head_data, skid_data, head_data_d;
  logic [R-1:0]  head_wa, skid_wa, head_wa_d;
  logic          accept, pop;
  logic          head_load, head_clear, skid_load, skid_clear;
  logic          skid_vld_next;

  // Lane packing: scalars occupy the low bits, vectors sit above them.
  if (NV > 0) begin : g_vec
    assign in_data    = {in_vector, in_scalar};
    assign out_vector = head_data[DW-1 -: NV*V];
  end else begin : g_novec
    assign in_data    = in_scalar;
    assign out_vector = '0;
  end

  assign accept = in_valid & in_ready;
  assign pop    = head_vld & out_ready;

  // Head refills from skid when skid holds an entry, else from the input.
  assign head_load   = (pop & skid_vld) | (accept & (~head_vld | pop));
  assign head_clear  = pop & ~skid_vld & ~accept;
  assign skid_load   = accept & head_vld & ~pop;
  assign skid_clear  = pop & skid_vld;
  assign head_ctrl_d = skid_vld ? skid_ctrl : in_ctrl;
  assign head_data_d = skid_vld ? skid_data : in_data;
  assign head_wa_d   = skid_vld ? skid_wa   : in_wa;

  assign skid_vld_next = skid_load | (skid_vld & ~skid_clear);

  pipe_slot #(.DW(DW), .C(C), .R(R)) u_head (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .load   (head_load),
    .clear  (head_clear),
    .d_ctrl (head_ctrl_d),
    .d_data (head_data_d),
    .d_wa   (head_wa_d),
    .valid  (head_vld),
    .ctrl   (head_ctrl),
    .data   (head_data),
    .wa     (head_wa)
  );

  pipe_slot #(.DW(DW), .C(C), .R(R)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .d_wa   (in_wa),
    .valid  (skid_vld),
    .ctrl   (skid_ctrl),
    .data   (skid_data),
    .wa     (skid_wa)
  );

  // Upstream ready is registered so no combinational path crosses the stage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= ~skid_vld_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (head_vld && !out_ready) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

  assign out_valid  = head_vld;
  assign out_ctrl   = head_ctrl & {C{head_vld}};
  assign out_scalar = head_data[NS*N-1:0];
  assign out_wa     = head_wa;
  assign occupancy  = skid_vld ? OCC_FULL : (head_vld ? OCC_ONE : OCC_EMPTY);

endmodule

// File: doc/pipeline_skid_register.md
Name: pipeline_skid_register

Overview:
- Parametrised successor to the fixed stage-boundary registers of the SIMD AES pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one control bundle, NS scalar lanes, NV vector lanes and a write address per entry.
- Adds valid/ready handshaking, a 2-entry skid buffer (registered upstream ready), flush-to-bubble, control gating on bubbles and a saturating stall-cycle counter.
- Any stage boundary instantiates it; the hazard unit drives flush and observes occupancy.

Parameters:
N, 32, scalar lane width
V, 256, vector lane width
NS, 2, number of scalar lanes (e.g. ALUResult, ReadData)
NV, 2, number of vector lanes
C, 4, control bundle width (e.g. PCSrc, RegWrite, RegWriteV, MemtoReg)
R, 5, register write-address width
SC, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries (bubble insertion)
in_valid  in  1  upstream entry present
in_ready  out  1  registered; buffer can accept an entry this cycle
in_ctrl  in  C  control bundle
in_scalar  in  NS*N  scalar lanes, lane k at bits [k*N +: N]
in_vector  in  NV*V  vector lanes, lane k at bits [k*V +: V]
in_wa  in  R  write address
out_valid  out  1  head entry present
out_ready  in  1  downstream consumes head (inverse of stall)
out_ctrl  out  C  head control, forced 0 when out_valid=0
out_scalar  out  NS*N  head scalar lanes
out_vector  out  NV*V  head vector lanes
out_wa  out  R  head write address
occupancy  out  2  entries held (0..2)
stall_cycles  out  SC  saturating count of cycles with out_valid & ~out_ready

Behaviour:
- Storage: head slot (drives outputs directly, no combinational path from in_* to out_*) and skid slot. Each slot holds valid, ctrl, scalar, vector and wa.
- Reset (rst=1 at edge): both valids=0, all ctrl/data/wa=0, in_ready=1, occupancy=0, stall_cycles=0. Reset overrides flush and handshakes.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready next-state = ~(skid valid in next state); in_ready is a flop output.
- occupancy 0: accept loads head. Latency in→out is 1 cycle.
- occupancy 1:
  - accept & pop: head <= input.
  - accept & ~pop: skid <= input.
  - pop only: head empties.
- occupancy 2: in_ready=0, so no accept.
  - pop: head <= skid; skid empties; in_ready returns 1 next cycle.
- Entries leave in strict FIFO order; no entry is duplicated or dropped except by flush.
- Flush (takes priority over accept and pop):
  - Next state: both valids=0, both stored ctrl=0, in_ready=1.
  - Data and wa are not cleared.
  - An entry presented in the flush cycle is dropped and in_ready stays 1.
  - A pop in the flush cycle still counts as consumed downstream.
- out_ctrl = head ctrl AND out_valid, so a bubble never asserts RegWrite-type controls.
- stall_cycles increments when out_valid & ~out_ready, holds at 2^SC-1 and clears only on rst (not on flush).
- Width rules:
  - Lane packing is little-endian by lane index.
  - Port widths equal the parameter products; no truncation or extension inside the block.
- Parameter checks: NS≥1, NV≥0 (NV=0 removes the vector ports' storage; ports kept 1 bit wide, tied 0), C≥1.

Decomposition:
- Package pipe_pkg holds:
  - the default widths N_DEF=32, V_DEF=256, R_DEF=5;
  - typedef pipe_ctrl_t as a packed struct {pc_src, reg_write, reg_write_v, mem_to_reg}, which all stage instances cast in_ctrl to;
  - the occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
- Sub-module pipe_slot: one entry (valid, ctrl, data, wa) with load/clear/flush inputs, instantiated twice (head, skid).

Test Plan:
- Reset then one accept: rst 2 cycles, then in_valid=1, in_ctrl=4'b1010, in_scalar lane0=32'hDEADBEEF, out_ready=1 → next cycle out_valid=1, out_ctrl=4'b1010, lane0=DEADBEEF, occupancy=1; all outputs 0 during reset.
- Skid fill: out_ready=0, present A then B → occupancy=2, in_ready=0 on cycle 3, head=A. Raise out_ready → A, then B, on consecutive cycles; in_ready=1 one cycle after A pops.
- Back-to-back streaming: out_ready=1, 8 consecutive entries with wa=0..7 → out_wa 0..7 in order, one per cycle, occupancy never exceeds 1, stall_cycles=0.
- Flush with full buffer plus incoming C: flush=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, C absent. Next accepted entry appears normally.
- Stall counter saturation with SC=4: out_valid=1, out_ready=0 for 20 cycles → stall_cycles reaches 15 and holds. A flush leaves it at 15; rst clears it to 0.
- Reset mid-transfer: occupancy=2 and in_valid=1 when rst asserts with flush=1 → next cycle all state 0, in_ready=1, nothing emitted afterwards until a new accept.
